// File: rtl/trace_feeder_if.sv
// Branch/prediction/update bundle between the trace feeder (master) and the
// predictor core (slave).
interface trace_feeder_if #(
  parameter int PC_WIDTH = 32
);
  // Handshake: a branch transfers on a rising edge where BranchValid and
  // BranchReady are both 1; until then BranchValid stays high and BranchPC
  // stays stable. PredValid/Prediction and UpdateValid/ActualTaken/Mispredict
  // are single-cycle strobes with no back-pressure.
  logic                BranchValid;
  logic                BranchReady;
  logic [PC_WIDTH-1:0] BranchPC;
  logic                PredValid;
  logic                Prediction;
  logic                UpdateValid;
  logic                ActualTaken;
  logic                Mispredict;

  modport master (
    output BranchValid,
    output BranchPC,
    input  BranchReady,
    input  PredValid,
    input  Prediction,
    output UpdateValid,
    output ActualTaken,
    output Mispredict
  );

  modport slave (
    input  BranchValid,
    input  BranchPC,
    output BranchReady,
    output PredValid,
    output Prediction,
    input  UpdateValid,
    input  ActualTaken,
    input  Mispredict
  );
endinterface

// File: rtl/trace_feeder.sv
// Replays a preloaded branch trace into the predictor one entry at a time,
// reports the actual outcome and mispredict flag, and counts both.
module trace_feeder #(
  parameter int TRAINING_DATA_SIZE     = 256,
  parameter int INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE),
  parameter int PC_WIDTH               = 32,
  parameter int TRACE_LENGTH           = 256
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Start,
  input  logic                              LoadEn,
  input  logic [INSTRUCTION_INDEX_SIZE-1:0] LoadAddr,
  input  logic [PC_WIDTH-1:0]               LoadPC,
  input  logic                              LoadTaken,
  input  logic [INSTRUCTION_INDEX_SIZE-1:0] InstructionNumber,
  output logic                              IncEn,
  output logic [INSTRUCTION_INDEX_SIZE:0]   BranchCount,
  output logic [INSTRUCTION_INDEX_SIZE:0]   MispredCount,
  output logic                              Done,
  output logic [2:0]                        DbgState,
  trace_feeder_if.master                    pred_if
);

  localparam int CNT_W = INSTRUCTION_INDEX_SIZE + 1;
  localparam logic [INSTRUCTION_INDEX_SIZE-1:0] LAST_IDX =
    INSTRUCTION_INDEX_SIZE'(TRACE_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_PRED = 3'd3,
    S_UPDATE    = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state_q;
  logic [PC_WIDTH:0]     mem_q [TRAINING_DATA_SIZE];
  logic [PC_WIDTH-1:0]   branch_pc_q;
  logic                  taken_q;
  logic                  branch_valid_q;
  logic                  update_valid_q;
  logic                  actual_taken_q;
  logic                  mispredict_q;
  logic                  inc_en_q;
  logic                  done_q;
  logic [CNT_W-1:0]      branch_cnt_q;
  logic [CNT_W-1:0]      mispred_cnt_q;

  logic                  last_entry_d;
  logic                  mispredict_d;
  logic                  load_we_d;

  assign last_entry_d = (InstructionNumber == LAST_IDX);
  assign mispredict_d = pred_if.Prediction ^ taken_q;
  assign load_we_d    = Rst && LoadEn && (state_q == S_IDLE);

  // Trace RAM: no reset so the loaded trace survives Rst between runs.
  always_ff @(posedge Clk) begin
    if (load_we_d) begin
      mem_q[LoadAddr] <= {LoadPC, LoadTaken};
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q        <= S_IDLE;
      branch_pc_q    <= '0;
      taken_q        <= 1'b0;
      branch_valid_q <= 1'b0;
      update_valid_q <= 1'b0;
      actual_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      inc_en_q       <= 1'b0;
      done_q         <= 1'b0;
      branch_cnt_q   <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      update_valid_q <= 1'b0;
      inc_en_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            state_q       <= S_READ;
          end
        end
        S_READ: begin
          {branch_pc_q, taken_q} <= mem_q[InstructionNumber];
          branch_valid_q         <= 1'b1;
          state_q                <= S_ISSUE;
        end
        // PredValid is deliberately not looked at until the branch is accepted.
        S_ISSUE: begin
          if (pred_if.BranchReady) begin
            branch_valid_q <= 1'b0;
            state_q        <= S_WAIT_PRED;
          end
        end
        S_WAIT_PRED: begin
          if (pred_if.PredValid) begin
            mispredict_q   <= mispredict_d;
            actual_taken_q <= taken_q;
            update_valid_q <= 1'b1;
            inc_en_q       <= !last_entry_d;
            state_q        <= S_UPDATE;
          end
        end
        // The incrementer advances on the edge leaving UPDATE, so READ
        // already sees the next index.
        S_UPDATE: begin
          branch_cnt_q  <= branch_cnt_q + 1'b1;
          mispred_cnt_q <= mispred_cnt_q + CNT_W'(mispredict_q);
          if (last_entry_d) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_READ;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pred_if.BranchValid = branch_valid_q;
  assign pred_if.BranchPC    = branch_pc_q;
  assign pred_if.UpdateValid = update_valid_q;
  assign pred_if.ActualTaken = actual_taken_q;
  assign pred_if.Mispredict  = mispredict_q;
  assign IncEn               = inc_en_q;
  assign BranchCount         = branch_cnt_q;
  assign MispredCount        = mispred_cnt_q;
  assign Done                = done_q;
  assign DbgState            = state_q;

endmodule

// File: tb/tb_trace_feeder.sv
// Bench for trace_feeder: a 4-entry instance exercising handshake corners and
// reset, and a 256-entry instance checking full-length counting.
module tb_trace_feeder;

  localparam int IW = 8;
  localparam int PW = 32;
  localparam int EW = PW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: TRACE_LENGTH = 4 ----------------
  logic          a_rst, a_start, a_load_en, a_load_taken, a_inc, a_done;
  logic [IW-1:0] a_load_addr, a_idx;
  logic [PW-1:0] a_load_pc;
  logic [IW:0]   a_bcnt, a_mcnt;
  logic [2:0]    a_dbg;
  trace_feeder_if #(.PC_WIDTH(PW)) if_a ();

  trace_feeder #(.TRAINING_DATA_SIZE(256), .PC_WIDTH(PW), .TRACE_LENGTH(4)) dut_a (
    .Clk(clk), .Rst(a_rst), .Start(a_start), .LoadEn(a_load_en),
    .LoadAddr(a_load_addr), .LoadPC(a_load_pc), .LoadTaken(a_load_taken),
    .InstructionNumber(a_idx), .IncEn(a_inc), .BranchCount(a_bcnt),
    .MispredCount(a_mcnt), .Done(a_done), .DbgState(a_dbg), .pred_if(if_a)
  );

  always_ff @(posedge clk or negedge a_rst)
    if (!a_rst) a_idx <= '0;
    else if (a_inc) a_idx <= a_idx + 1'b1;

  logic [PW-1:0] a_pc_m [4];
  logic          a_tk_m [4];
  logic          a_pred_taken = 1'b1;
  int            a_hold = 0, a_delay = 0;
  bit            a_spurious = 1'b0;
  logic [EW-1:0] exp_a_q [$];
  int            a_upd_cnt = 0, a_inc_cnt = 0, a_last_cyc = -1;
  bit            a_chk_lat = 1'b0;

  // Predictor model for A: programmable ready hold-off and prediction delay.
  initial begin
    int phase = 0;
    int cnt   = 0;
    if_a.BranchReady = 1'b0; if_a.PredValid = 1'b0; if_a.Prediction = 1'b0;
    forever begin
      @(negedge clk);
      if (!a_rst) begin
        phase = 0; if_a.BranchReady = 1'b0; if_a.PredValid = 1'b0;
      end else begin
        case (phase)
          0: if (if_a.BranchValid) begin
               check_eq("a_offer_pc", 64'(if_a.BranchPC), 64'(a_pc_m[a_idx[1:0]]));
               if (a_hold == 0) begin
                 if_a.BranchReady = 1'b1; phase = 2;
               end else begin
                 if_a.BranchReady = 1'b0; cnt = 0; phase = 1;
                 if_a.PredValid = a_spurious; if_a.Prediction = ~a_pred_taken;
               end
             end
          1: begin
               if_a.PredValid = 1'b0;
               check_eq("a_hold_valid", 64'(if_a.BranchValid), 64'(1));
               check_eq("a_hold_pc", 64'(if_a.BranchPC), 64'(a_pc_m[a_idx[1:0]]));
               cnt++;
               if (cnt == a_hold) begin if_a.BranchReady = 1'b1; phase = 2; end
             end
          2: begin
               if_a.BranchReady = 1'b0;
               if (a_delay == 0) begin
                 if_a.PredValid = 1'b1; if_a.Prediction = a_pred_taken; phase = 4;
               end else begin
                 cnt = 0; phase = 3;
               end
             end
          3: begin
               cnt++;
               if (cnt == a_delay) begin
                 if_a.PredValid = 1'b1; if_a.Prediction = a_pred_taken; phase = 4;
               end
             end
          default: begin if_a.PredValid = 1'b0; phase = 0; end
        endcase
      end
    end
  end

  // Scoreboard / monitor for A.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (a_rst && if_a.UpdateValid) begin
        a_upd_cnt++;
        if (exp_a_q.size() == 0) begin
          check_eq("a_unexpected_update", 64'(1), 64'(0));
        end else begin
          e = exp_a_q.pop_front();
          check_eq("a_update", 64'({if_a.BranchPC, if_a.ActualTaken, if_a.Mispredict}), 64'(e));
        end
        if (a_chk_lat && a_last_cyc >= 0) check_eq("a_branch_latency", 64'(cyc - a_last_cyc), 64'(4));
        a_last_cyc = cyc;
      end
      if (a_rst && a_inc) a_inc_cnt++;
    end
  end

  task automatic a_reset();
    a_rst = 1'b0;
    repeat (2) @(negedge clk);
    a_rst = 1'b1;
  endtask

  task automatic a_begin_run(input bit with_load, input logic [PW-1:0] pc0, input logic tk0);
    @(negedge clk);
    if (with_load) begin
      a_pc_m[0] = pc0; a_tk_m[0] = tk0;
      a_load_en = 1'b1; a_load_addr = '0; a_load_pc = pc0; a_load_taken = tk0;
    end
    exp_a_q.delete();
    for (int i = 0; i < 4; i++) exp_a_q.push_back({a_pc_m[i], a_tk_m[i], a_tk_m[i] ^ a_pred_taken});
    a_upd_cnt = 0; a_inc_cnt = 0; a_last_cyc = -1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_load_en = 1'b0;
  endtask

  task automatic a_pulse_load(input logic [IW-1:0] addr, input logic [PW-1:0] pc);
    a_load_en = 1'b1; a_load_addr = addr; a_load_pc = pc; a_load_taken = 1'b1;
    @(negedge clk);
    a_load_en = 1'b0;
  endtask

  task automatic a_finish_run(input string tag);
    int n = 0;
    int exp_mis = 0;
    while (!a_done && n < 800) begin @(negedge clk); n++; end
    check_eq({tag, "_done"}, 64'(a_done), 64'(1));
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) if (a_tk_m[i] != a_pred_taken) exp_mis++;
    check_eq({tag, "_bcount"}, 64'(a_bcnt), 64'(4));
    check_eq({tag, "_mcount"}, 64'(a_mcnt), 64'(exp_mis));
    check_eq({tag, "_incen_pulses"}, 64'(a_inc_cnt), 64'(3));
    check_eq({tag, "_updates"}, 64'(a_upd_cnt), 64'(4));
    check_eq({tag, "_queue_empty"}, 64'(exp_a_q.size()), 64'(0));
  endtask

  task automatic a_check_zero(input string tag);
    check_eq({tag, "_bvalid"}, 64'(if_a.BranchValid), 64'(0));
    check_eq({tag, "_uvalid"}, 64'(if_a.UpdateValid), 64'(0));
    check_eq({tag, "_incen"}, 64'(a_inc), 64'(0));
    check_eq({tag, "_pc"}, 64'(if_a.BranchPC), 64'(0));
    check_eq({tag, "_actual"}, 64'(if_a.ActualTaken), 64'(0));
    check_eq({tag, "_mispred"}, 64'(if_a.Mispredict), 64'(0));
    check_eq({tag, "_counts"}, 64'({a_bcnt, a_mcnt}), 64'(0));
    check_eq({tag, "_done"}, 64'(a_done), 64'(0));
  endtask

  // ---------------- instance B: TRACE_LENGTH = 256 ----------------
  logic          b_rst, b_start, b_load_en, b_load_taken, b_inc, b_done;
  logic [IW-1:0] b_load_addr, b_idx;
  logic [PW-1:0] b_load_pc;
  logic [IW:0]   b_bcnt, b_mcnt;
  logic [2:0]    b_dbg;
  trace_feeder_if #(.PC_WIDTH(PW)) if_b ();

  trace_feeder #(.TRAINING_DATA_SIZE(256), .PC_WIDTH(PW), .TRACE_LENGTH(256)) dut_b (
    .Clk(clk), .Rst(b_rst), .Start(b_start), .LoadEn(b_load_en),
    .LoadAddr(b_load_addr), .LoadPC(b_load_pc), .LoadTaken(b_load_taken),
    .InstructionNumber(b_idx), .IncEn(b_inc), .BranchCount(b_bcnt),
    .MispredCount(b_mcnt), .Done(b_done), .DbgState(b_dbg), .pred_if(if_b)
  );

  always_ff @(posedge clk or negedge b_rst)
    if (!b_rst) b_idx <= '0;
    else if (b_inc) b_idx <= b_idx + 1'b1;

  logic [EW-1:0] exp_b_q [$];
  int            b_upd_cnt = 0, b_inc_cnt = 0;

  // B predictor: ready tied high, always predicts not-taken one cycle after acceptance.
  initial begin
    bit acc = 1'b0;
    if_b.BranchReady = 1'b1; if_b.PredValid = 1'b0; if_b.Prediction = 1'b0;
    forever begin
      @(negedge clk);
      if_b.PredValid = acc && b_rst;
      acc = if_b.BranchValid && b_rst;
      if (b_rst && if_b.UpdateValid) begin
        b_upd_cnt++;
        if (exp_b_q.size() == 0) check_eq("b_unexpected_update", 64'(1), 64'(0));
        else check_eq("b_update", 64'({if_b.BranchPC, if_b.ActualTaken, if_b.Mispredict}),
                      64'(exp_b_q.pop_front()));
      end
      if (b_rst && b_inc) b_inc_cnt++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    a_rst = 1'b0; a_start = 1'b0; a_load_en = 1'b0; a_load_addr = '0; a_load_pc = '0; a_load_taken = 1'b0;
    b_rst = 1'b0; b_start = 1'b0; b_load_en = 1'b0; b_load_addr = '0; b_load_pc = '0; b_load_taken = 1'b0;
    a_pc_m[0] = 32'h100; a_tk_m[0] = 1'b1;
    a_pc_m[1] = 32'h104; a_tk_m[1] = 1'b0;
    a_pc_m[2] = 32'h108; a_tk_m[2] = 1'b1;
    a_pc_m[3] = 32'h10C; a_tk_m[3] = 1'b0;
    repeat (3) @(negedge clk);
    a_check_zero("reset");
    a_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      a_load_en = 1'b1; a_load_addr = IW'(i); a_load_pc = a_pc_m[i]; a_load_taken = a_tk_m[i];
      @(negedge clk);
    end
    a_load_en = 1'b0;

    // Nominal run: ready immediate, prediction immediate, always taken.
    a_chk_lat = 1'b1;
    a_begin_run(1'b0, '0, 1'b0);
    a_finish_run("nominal");
    a_chk_lat = 1'b0;

    // Done is sticky: Start and LoadEn ignored.
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    a_pulse_load(8'd2, 32'hBAD0);
    repeat (3) @(negedge clk);
    check_eq("done_sticky", 64'(a_done), 64'(1));
    check_eq("done_counts_held", 64'({a_bcnt, a_mcnt}), 64'({9'd4, 9'd2}));

    // Ready held low 5 cycles per branch, LoadEn pulses during the run.
    a_reset();
    a_hold = 5;
    a_begin_run(1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    a_pulse_load(8'd1, 32'hDEAD);
    repeat (7) @(negedge clk);
    a_pulse_load(8'd3, 32'hBEEF);
    a_finish_run("ready_hold");

    // Prediction delayed 10 cycles with a spurious PredValid while in ISSUE.
    a_reset();
    a_hold = 2; a_delay = 10; a_spurious = 1'b1;
    a_begin_run(1'b0, '0, 1'b0);
    a_finish_run("pred_delay");
    a_hold = 0; a_spurious = 1'b0;

    // Asynchronous reset while waiting for the prediction of entry 2.
    a_reset();
    a_begin_run(1'b0, '0, 1'b0);
    n = 0;
    while (!(a_idx == 8'd2 && a_dbg == 3'd3) && n < 300) begin @(negedge clk); n++; end
    check_eq("abort_reached_wait", 64'({a_idx, a_dbg}), 64'({8'd2, 3'd3}));
    #2 a_rst = 1'b0;
    #1 a_check_zero("abort");
    check_eq("abort_updates_before", 64'(a_upd_cnt), 64'(2));
    @(negedge clk);
    check_eq("abort_no_partial_update", 64'(a_upd_cnt), 64'(2));
    exp_a_q.delete();
    a_rst = 1'b1;
    a_delay = 0;
    a_chk_lat = 1'b1;
    a_begin_run(1'b0, '0, 1'b0);
    a_finish_run("rerun");
    a_chk_lat = 1'b0;

    // Load and start in the same cycle: first issued PC is the new one.
    a_reset();
    a_begin_run(1'b1, 32'h200, 1'b1);
    a_finish_run("load_start");

    // Full-length run on B: every entry taken, predictor never taken.
    b_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      b_load_en = 1'b1; b_load_addr = IW'(i); b_load_pc = 32'h1000 + 32'(4 * i); b_load_taken = 1'b1;
      exp_b_q.push_back({32'h1000 + 32'(4 * i), 1'b1, 1'b1});
      @(negedge clk);
    end
    b_load_en = 1'b0;
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    n = 0;
    while (!b_done && n < 3000) begin @(negedge clk); n++; end
    check_eq("full_done", 64'(b_done), 64'(1));
    repeat (2) @(negedge clk);
    check_eq("full_bcount", 64'(b_bcnt), 64'(256));
    check_eq("full_mcount", 64'(b_mcnt), 64'(256));
    check_eq("full_incen_pulses", 64'(b_inc_cnt), 64'(255));
    check_eq("full_updates", 64'(b_upd_cnt), 64'(256));
    check_eq("full_final_index", 64'(b_idx), 64'(255));
    check_eq("full_queue_empty", 64'(exp_b_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trace_feeder.md
Name: trace_feeder

Overview:
- Sits directly downstream of the instruction-number incrementer and upstream of the TAGE predictor core.
- Holds the training branch trace (PC plus actual outcome) in an internal RAM, loaded before a run.
- Reads the entry addressed by the incrementer's InstructionNumber and issues it to the predictor over a valid/ready handshake.
- Waits for the prediction, emits the update (actual outcome and mispredict flag), counts branches and mispredictions, then pulses the incrementer enable to advance to the next entry.

Parameters:
- TRAINING_DATA_SIZE, 256: number of trace entries in the RAM.
- INSTRUCTION_INDEX_SIZE, $clog2(TRAINING_DATA_SIZE): width of the index and load address.
- PC_WIDTH, 32: branch PC width.
- TRACE_LENGTH, 256: entries processed per run; legal range 1..TRAINING_DATA_SIZE.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  begins a run; sampled only in IDLE.
- LoadEn  in  1  trace RAM write strobe; honoured only in IDLE.
- LoadAddr  in  INSTRUCTION_INDEX_SIZE  trace RAM write address.
- LoadPC  in  PC_WIDTH  PC to store.
- LoadTaken  in  1  actual outcome to store.
- InstructionNumber  in  INSTRUCTION_INDEX_SIZE  current index from the incrementer.
- IncEn  out  1  one-cycle enable to the incrementer.
- BranchValid  out  1  branch offered to the predictor.
- BranchReady  in  1  predictor accepts the branch.
- BranchPC  out  PC_WIDTH  PC of the offered branch.
- PredValid  in  1  predictor's prediction is available.
- Prediction  in  1  predicted taken.
- UpdateValid  out  1  one-cycle update strobe.
- ActualTaken  out  1  actual outcome; valid with UpdateValid.
- Mispredict  out  1  Prediction != ActualTaken; valid with UpdateValid.
- BranchCount  out  INSTRUCTION_INDEX_SIZE+1  branches retired this run.
- MispredCount  out  INSTRUCTION_INDEX_SIZE+1  mispredictions this run.
- Done  out  1  run complete; sticky.

Behaviour:
- Reset (Rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs and counters are 0.
  - Trace RAM contents are not cleared and remain valid.
  - Reset mid-run aborts the run immediately; no partial update is emitted.
- FSM states are IDLE, READ, ISSUE, WAIT_PRED, UPDATE, DONE.
- IDLE:
  - LoadEn=1 writes {LoadPC, LoadTaken} to RAM[LoadAddr] at the clock edge.
  - Start=1 clears both counters and moves to READ.
  - LoadEn and Start in the same cycle: the write completes and the run starts. A read of that address in READ returns the new data.
- READ:
  - Synchronous RAM read at address InstructionNumber; data is registered at the end of the cycle.
  - Always moves to ISSUE.
- ISSUE:
  - BranchValid=1 and BranchPC is held stable until BranchReady=1.
  - On the handshake cycle, move to WAIT_PRED. BranchValid drops the next cycle.
  - PredValid is ignored in ISSUE. The predictor asserts PredValid no earlier than the cycle after acceptance.
- WAIT_PRED:
  - Waits indefinitely for PredValid=1.
  - On PredValid=1, registers Mispredict = Prediction XOR stored taken, then moves to UPDATE.
- UPDATE (exactly one cycle):
  - UpdateValid=1, with ActualTaken and Mispredict valid.
  - BranchCount increments by 1; MispredCount increments by 1 if Mispredict=1.
  - If InstructionNumber == TRACE_LENGTH-1: IncEn=0, go to DONE.
  - Otherwise: IncEn=1, go to READ. The incrementer updates on this edge, so READ sees the new index.
- DONE:
  - Done=1; counters are held.
  - Start and LoadEn are ignored; only Rst leaves DONE.
- Per-branch latency, with BranchReady and PredValid returning at the earliest possible cycle: 4 cycles (READ, ISSUE, WAIT_PRED, UPDATE).
- Outputs other than BranchValid, UpdateValid and IncEn hold their last value when not strobed.
- Counter width INSTRUCTION_INDEX_SIZE+1 holds a value of 256 without wrapping.

Test Plan:
- Load 4 entries (PC 0x100/T, 0x104/N, 0x108/T, 0x10C/N), TRACE_LENGTH=4, predictor always returns taken, BranchReady tied 1 → BranchPC sequence 0x100, 0x104, 0x108, 0x10C; Mispredict 0,1,0,1; 3 IncEn pulses; BranchCount=4, MispredCount=2, Done=1.
- BranchReady held low 5 cycles in ISSUE → BranchValid and BranchPC stable for all 5 cycles; exactly one UpdateValid per branch.
- PredValid delayed 10 cycles, plus a spurious PredValid pulse during ISSUE → pulse ignored; counts unchanged from the nominal run.
- Rst asserted during WAIT_PRED of entry 2 → all outputs 0 asynchronously. After release, Start reruns from index 0 with RAM data intact and counters restarting at 0.
- TRACE_LENGTH=256, all entries taken, predictor always not-taken → BranchCount=256, MispredCount=256 with no wrap; Done=1; no IncEn on the final entry.
- LoadEn+Start in the same cycle to address 0 → the first BranchPC equals the newly written PC. LoadEn pulses during the run leave RAM unchanged.
